// File: rtl/mem_responder_if.sv
// Request/response bus between a control unit and the mem_responder wait-state memory.
// The master drives requests and preload writes; the slave returns registered status and data.
interface mem_responder_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8
) ();
    logic              mem_rd;
    logic              mem_wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              init_wr;
    logic [ADDR_W-1:0] init_addr;
    logic [DATA_W-1:0] init_data;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              wr_done;
    logic              busy;
    logic              err;

    modport master (
        output mem_rd, mem_wr, addr, wdata, init_wr, init_addr, init_data,
        input  rdata, rvalid, wr_done, busy, err
    );

    modport slave (
        input  mem_rd, mem_wr, addr, wdata, init_wr, init_addr, init_data,
        output rdata, rvalid, wr_done, busy, err
    );
endinterface

// File: rtl/mem_responder.sv
// Edge-triggered single-port memory responder with a fixed number of wait states.
// Requests are rising edges of mem_rd/mem_wr; all outputs are registered.
module mem_responder #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic          clock,
    input  logic          reset,
    mem_responder_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_n;
    logic              rd_q;
    logic              wr_q;
    logic [ADDR_W-1:0] lat_addr;
    logic [ADDR_W-1:0] lat_addr_n;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] lat_wdata_n;
    logic              lat_rd;
    logic              lat_rd_n;
    logic              rd_edge;
    logic              wr_edge;
    logic              accept;
    logic              err_n;
    logic              rd_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd;

    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;
    logic              wr_done_q;
    logic              busy_q;
    logic              err_q;

    logic [DATA_W-1:0] mem [DEPTH];

    // Next state, latched request and the single memory port selection.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        lat_addr_n  = lat_addr;
        lat_wdata_n = lat_wdata;
        lat_rd_n    = lat_rd;
        accept      = 1'b0;
        err_n       = 1'b0;
        rd_en       = 1'b0;
        mem_we      = 1'b0;
        mem_wa      = lat_addr;
        mem_wd      = lat_wdata;
        rd_edge     = bus.mem_rd & ~rd_q;
        wr_edge     = bus.mem_wr & ~wr_q;

        case (state)
            IDLE: begin
                if ((rd_edge || wr_edge) && bus.mem_rd && bus.mem_wr) begin
                    err_n = 1'b1;
                end else if (rd_edge || wr_edge) begin
                    accept      = 1'b1;
                    lat_addr_n  = bus.addr;
                    lat_wdata_n = bus.wdata;
                    lat_rd_n    = rd_edge;
                    cnt_n       = CNT_W'(WAIT_CYCLES);
                    state_n     = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
                // Preload only uses the port when no access claims it.
                if (!accept && bus.init_wr) begin
                    mem_we = 1'b1;
                    mem_wa = bus.init_addr;
                    mem_wd = bus.init_data;
                end
            end
            WAIT: begin
                if (cnt <= CNT_W'(1)) begin
                    cnt_n   = '0;
                    state_n = RESP;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            RESP: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase

        // The access happens on the edge that enters RESP so the pulse lines up with it.
        if (state_n == RESP) begin
            if (lat_rd_n) begin
                rd_en = 1'b1;
            end else begin
                mem_we = 1'b1;
                mem_wa = lat_addr_n;
                mem_wd = lat_wdata_n;
            end
        end
    end

    // State, request history and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_rd    <= 1'b0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            wr_done_q <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            rd_q      <= bus.mem_rd;
            wr_q      <= bus.mem_wr;
            lat_addr  <= lat_addr_n;
            lat_wdata <= lat_wdata_n;
            lat_rd    <= lat_rd_n;
            rvalid_q  <= (state_n == RESP) && lat_rd_n;
            wr_done_q <= (state_n == RESP) && !lat_rd_n;
            busy_q    <= (state_n != IDLE);
            err_q     <= err_n;
            if (rd_en) begin
                rdata_q <= mem[lat_addr_n];
            end
        end
    end

    // Storage is not cleared by reset; reset only blocks the write.
    always_ff @(posedge clock) begin
        if (!reset && mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    assign bus.rdata   = rdata_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.wr_done = wr_done_q;
    assign bus.busy    = busy_q;
    assign bus.err     = err_q;

endmodule
